// File: rtl/axi4_lite_arbiter.sv
// rtl/axi4_lite_arbiter.sv - N-to-1 AXI4-Lite arbiter, independent round-robin read/write paths
// One outstanding transaction per direction; grant is registered one cycle after a request appears.
module axi4_lite_arbiter #(
  parameter int N   = 2,
  parameter int A_W = 32,
  parameter int D_W = 32,
  localparam int S_W = D_W / 8,
  localparam int G_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [N-1:0]       s_awvalid,
  output logic [N-1:0]       s_awready,
  input  logic [N*A_W-1:0]   s_awaddr,
  input  logic [N-1:0]       s_wvalid,
  output logic [N-1:0]       s_wready,
  input  logic [N*D_W-1:0]   s_wdata,
  input  logic [N*S_W-1:0]   s_wstrb,
  output logic [N-1:0]       s_bvalid,
  input  logic [N-1:0]       s_bready,
  output logic [N*2-1:0]     s_bresp,
  input  logic [N-1:0]       s_arvalid,
  output logic [N-1:0]       s_arready,
  input  logic [N*A_W-1:0]   s_araddr,
  output logic [N-1:0]       s_rvalid,
  input  logic [N-1:0]       s_rready,
  output logic [N*D_W-1:0]   s_rdata,
  output logic [N*2-1:0]     s_rresp,
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic [A_W-1:0]     m_awaddr,
  output logic               m_wvalid,
  input  logic               m_wready,
  output logic [D_W-1:0]     m_wdata,
  output logic [S_W-1:0]     m_wstrb,
  input  logic               m_bvalid,
  output logic               m_bready,
  input  logic [1:0]         m_bresp,
  output logic               m_arvalid,
  input  logic               m_arready,
  output logic [A_W-1:0]     m_araddr,
  input  logic               m_rvalid,
  output logic               m_rready,
  input  logic [D_W-1:0]     m_rdata,
  input  logic [1:0]         m_rresp,
  output logic [G_W-1:0]     wr_grant,
  output logic [G_W-1:0]     rd_grant,
  output logic               wr_busy,
  output logic               rd_busy
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

  wr_state_e      wr_state_q, wr_state_d;
  rd_state_e      rd_state_q, rd_state_d;
  logic [G_W-1:0] wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
  logic [G_W-1:0] rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;
  logic           aw_done_q, aw_done_d, w_done_q, w_done_d;

  // First requester at or above ptr, wrapping modulo N.
  function automatic logic [G_W-1:0] rr_pick(input logic [N-1:0] req, input logic [G_W-1:0] ptr);
    logic [G_W-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[G_W-1:0]]) begin
        pick  = idx[G_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [G_W-1:0] rr_next(input logic [G_W-1:0] g);
    return (g == G_W'(N - 1)) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_bresp    = '0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_awaddr   = s_awaddr[wr_grant_q*A_W +: A_W];
    m_wdata    = s_wdata[wr_grant_q*D_W +: D_W];
    m_wstrb    = s_wstrb[wr_grant_q*S_W +: S_W];
    case (wr_state_q)
      W_IDLE: begin
        if (|s_awvalid) begin
          wr_grant_d = rr_pick(s_awvalid, wr_ptr_q);
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        // done flags mask the channel that already handshook so it is never forwarded twice
        m_awvalid             = s_awvalid[wr_grant_q] & ~aw_done_q;
        s_awready[wr_grant_q] = m_awready & ~aw_done_q;
        m_wvalid              = s_wvalid[wr_grant_q] & ~w_done_q;
        s_wready[wr_grant_q]  = m_wready & ~w_done_q;
        aw_done_d             = aw_done_q | (m_awvalid & m_awready);
        w_done_d              = w_done_q | (m_wvalid & m_wready);
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        s_bvalid[wr_grant_q]          = m_bvalid;
        m_bready                      = s_bready[wr_grant_q];
        s_bresp[wr_grant_q*2 +: 2]    = m_bresp;
        if (m_bvalid && s_bready[wr_grant_q]) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_ptr_d   = rr_next(wr_grant_q);
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    s_arready  = '0;
    s_rvalid   = '0;
    s_rdata    = '0;
    s_rresp    = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_araddr   = s_araddr[rd_grant_q*A_W +: A_W];
    case (rd_state_q)
      R_IDLE: begin
        if (|s_arvalid) begin
          rd_grant_d = rr_pick(s_arvalid, rd_ptr_q);
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid             = s_arvalid[rd_grant_q];
        s_arready[rd_grant_q] = m_arready;
        if (m_arvalid && m_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_rvalid[rd_grant_q]          = m_rvalid;
        m_rready                      = s_rready[rd_grant_q];
        s_rdata[rd_grant_q*D_W +: D_W] = m_rdata;
        s_rresp[rd_grant_q*2 +: 2]    = m_rresp;
        if (m_rvalid && s_rready[rd_grant_q]) begin
          rd_ptr_d   = rr_next(rd_grant_q);
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_grant_q <= '0;
      wr_ptr_q   <= '0;
      rd_grant_q <= '0;
      rd_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_grant_q <= wr_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_grant_q <= rd_grant_d;
      rd_ptr_q   <= rd_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;
  assign wr_busy  = (wr_state_q != W_IDLE);
  assign rd_busy  = (rd_state_q != R_IDLE);

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb/tb_axi4_lite_arbiter.sv - scoreboard bench for axi4_lite_arbiter (N=2)
// Stimulus pushes hand-computed expectations; a negedge monitor pops them on each handshake.
module tb_axi4_lite_arbiter;
  localparam int N = 2;
  localparam int A_W = 32;
  localparam int D_W = 32;

  logic aclk, aresetn;
  logic [N-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*A_W-1:0] s_awaddr, s_araddr;
  logic [N*D_W-1:0] s_wdata, s_rdata;
  logic [N*4-1:0] s_wstrb;
  logic [N*2-1:0] s_bresp, s_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [3:0] m_wstrb;
  logic [1:0] m_bresp, m_rresp;
  logic [0:0] wr_grant, rd_grant;
  logic wr_busy, rd_busy;

  axi4_lite_arbiter #(.N(N), .A_W(A_W), .D_W(D_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  typedef struct { int g; logic [31:0] addr; } addr_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } wdat_t;
  typedef struct { int m; logic [31:0] data; logic [1:0] resp; } resp_t;

  addr_t exp_aw[$], exp_ar[$];
  wdat_t exp_w[$];
  resp_t exp_b[$], exp_r[$];

  int checks = 0, errors = 0;
  int w_beats = 0, wv_cycles = 0, rv_wait0 = 0, rtrack_err = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slv_rdata(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
  endfunction

  // Downstream slave: AW/W always accepted unless the test stalls AW; B and R follow one cycle later.
  initial begin
    logic aw_seen, w_seen, ar_seen, bhs, rhs;
    logic [31:0] ar_addr;
    aw_seen = 0; w_seen = 0; ar_seen = 0; ar_addr = '0;
    forever begin
      @(negedge aclk);
      bhs = m_bvalid && m_bready;
      rhs = m_rvalid && m_rready;
      if (m_awvalid && m_awready) aw_seen = 1;
      if (m_wvalid && m_wready) w_seen = 1;
      if (m_arvalid && m_arready) begin ar_seen = 1; ar_addr = m_araddr; end
      @(posedge aclk); #1;
      if (!aresetn) begin
        aw_seen = 0; w_seen = 0; ar_seen = 0; m_bvalid = 0; m_rvalid = 0;
      end else begin
        if (bhs) m_bvalid = 0;
        else if (aw_seen && w_seen && !m_bvalid) begin
          m_bvalid = 1; m_bresp = bresp_cfg; aw_seen = 0; w_seen = 0;
        end
        if (rhs) m_rvalid = 0;
        else if (ar_seen && !m_rvalid) begin
          m_rvalid = 1; m_rdata = slv_rdata(ar_addr); m_rresp = rresp_cfg; ar_seen = 0;
        end
      end
    end
  end

  // Monitor: pops expectations on every handshake and checks that idle/non-granted slices stay quiet.
  initial begin
    addr_t ea; wdat_t ew; resp_t er;
    logic ok;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (m_wvalid) wv_cycles++;
        if (m_awvalid && m_awready) begin
          chk("aw_expected", 64'(exp_aw.size() > 0), 1);
          if (exp_aw.size() > 0) begin
            ea = exp_aw.pop_front();
            chk("aw_addr", 64'(m_awaddr), 64'(ea.addr));
            chk("aw_grant", 64'(wr_grant), 64'(ea.g));
          end
        end
        if (m_wvalid && m_wready) begin
          w_beats++;
          chk("w_expected", 64'(exp_w.size() > 0), 1);
          if (exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            chk("w_data", 64'(m_wdata), 64'(ew.data));
            chk("w_strb", 64'(m_wstrb), 64'(ew.strb));
          end
        end
        if (m_arvalid && m_arready) begin
          chk("ar_expected", 64'(exp_ar.size() > 0), 1);
          if (exp_ar.size() > 0) begin
            ea = exp_ar.pop_front();
            chk("ar_addr", 64'(m_araddr), 64'(ea.addr));
            chk("ar_grant", 64'(rd_grant), 64'(ea.g));
          end
        end
        for (int i = 0; i < N; i++) begin
          if (s_bvalid[i] && s_bready[i]) begin
            chk("b_expected", 64'(exp_b.size() > 0), 1);
            if (exp_b.size() > 0) begin
              er = exp_b.pop_front();
              chk("b_master", 64'(i), 64'(er.m));
              chk("b_resp", 64'(s_bresp[i*2 +: 2]), 64'(er.resp));
            end
          end
          if (s_rvalid[i] && s_rready[i]) begin
            chk("r_expected", 64'(exp_r.size() > 0), 1);
            if (exp_r.size() > 0) begin
              er = exp_r.pop_front();
              chk("r_master", 64'(i), 64'(er.m));
              chk("r_data", 64'(s_rdata[i*32 +: 32]), 64'(er.data));
              chk("r_resp", 64'(s_rresp[i*2 +: 2]), 64'(er.resp));
            end
          end
        end
        if (s_rvalid[0] && !s_rready[0]) rv_wait0++;
        if (s_rvalid[0] && (m_rready !== s_rready[0])) rtrack_err++;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (!(wr_busy && int'(wr_grant) == i) &&
              (s_awready[i] || s_wready[i] || s_bvalid[i] || (|s_bresp[i*2 +: 2]))) ok = 1'b0;
          if (!(rd_busy && int'(rd_grant) == i) &&
              (s_arready[i] || s_rvalid[i] || (|s_rresp[i*2 +: 2]) || (|s_rdata[i*32 +: 32]))) ok = 1'b0;
        end
        chk("exclusive_routing", 64'(ok), 1);
      end
    end
  end

  task automatic wr_txn(input int i, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t; logic a, w, b;
    s_awaddr[i*32 +: 32] = addr;
    s_wdata[i*32 +: 32]  = data;
    s_wstrb[i*4 +: 4]    = strb;
    s_awvalid[i] = 1; s_wvalid[i] = 1; s_bready[i] = 1;
    for (t = 0; t < 200; t++) begin
      @(negedge aclk);
      a = s_awvalid[i] && s_awready[i];
      w = s_wvalid[i] && s_wready[i];
      b = s_bvalid[i] && s_bready[i];
      @(posedge aclk); #1;
      if (a) s_awvalid[i] = 0;
      if (w) s_wvalid[i] = 0;
      if (b) begin s_bready[i] = 0; break; end
    end
    chk("wr_txn_timeout", 64'(t < 200), 1);
  endtask

  task automatic rd_txn(input int i, input logic [31:0] addr, input int rdelay);
    int t, cnt; logic a, rv, r;
    cnt = 0;
    s_araddr[i*32 +: 32] = addr;
    s_arvalid[i] = 1; s_rready[i] = (rdelay == 0);
    for (t = 0; t < 200; t++) begin
      @(negedge aclk);
      a  = s_arvalid[i] && s_arready[i];
      rv = s_rvalid[i];
      r  = rv && s_rready[i];
      @(posedge aclk); #1;
      if (a) s_arvalid[i] = 0;
      if (r) begin s_rready[i] = 0; break; end
      if (rv) begin cnt++; if (cnt >= rdelay) s_rready[i] = 1; end
    end
    chk("rd_txn_timeout", 64'(t < 200), 1);
  endtask

  initial begin
    int wb0, wv0, rv0, rt0, t;
    logic a, w, bv;
    aresetn = 0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    m_awready = 1; m_wready = 1; m_arready = 1;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    #7;
    chk("rst_m_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 0);
    chk("rst_s_handshake", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 0);
    chk("rst_grants_busy", 64'({wr_grant, rd_grant, wr_busy, rd_busy}), 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk); #1;

    // single write from master 1
    exp_aw.push_back('{1, 32'h10});
    exp_w.push_back('{32'hA5A5_A5A5, 4'hF});
    exp_b.push_back('{1, 32'h0, 2'b00});
    wr_txn(1, 32'h10, 32'hA5A5_A5A5, 4'hF);

    // two masters contending: grants must alternate starting from master 0
    bresp_cfg = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_aw.push_back('{0, 32'h100 + k}); exp_w.push_back('{32'h1000_0000 + k, 4'hF});
      exp_b.push_back('{0, 32'h0, 2'b11});
      exp_aw.push_back('{1, 32'h200 + k}); exp_w.push_back('{32'h2000_0000 + k, 4'hF});
      exp_b.push_back('{1, 32'h0, 2'b11});
    end
    fork
      for (int k = 0; k < 4; k++) wr_txn(0, 32'h100 + k, 32'h1000_0000 + k, 4'hF);
      for (int k = 0; k < 4; k++) wr_txn(1, 32'h200 + k, 32'h2000_0000 + k, 4'hF);
    join

    // W completes while AW is stalled downstream
    bresp_cfg = 2'b00;
    m_awready = 0;
    exp_aw.push_back('{0, 32'h30});
    exp_w.push_back('{32'h0BAD_F00D, 4'h3});
    exp_b.push_back('{0, 32'h0, 2'b00});
    wb0 = w_beats; wv0 = wv_cycles;
    fork
      wr_txn(0, 32'h30, 32'h0BAD_F00D, 4'h3);
      begin
        for (t = 0; t < 50 && w_beats == wb0; t++) @(negedge aclk);
        chk("t3_w_first", 64'(w_beats - wb0), 1);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("t3_w_held_low", 64'(m_wvalid), 0);
        chk("t3_aw_pending", 64'({m_awvalid, wr_busy}), 64'(2'b11));
        @(posedge aclk); #1 m_awready = 1;
      end
    join
    chk("t3_w_beats", 64'(w_beats - wb0), 1);
    chk("t3_wvalid_cycles", 64'(wv_cycles - wv0), 1);

    // concurrent read (master 0) and write (master 1)
    bresp_cfg = 2'b10;
    exp_aw.push_back('{1, 32'h44});
    exp_w.push_back('{32'h5555_AAAA, 4'hC});
    exp_b.push_back('{1, 32'h0, 2'b10});
    exp_ar.push_back('{0, 32'h20});
    exp_r.push_back('{0, 32'h1234_5678, 2'b00});
    fork
      wr_txn(1, 32'h44, 32'h5555_AAAA, 4'hC);
      rd_txn(0, 32'h20, 0);
    join

    // SLVERR read held by a stalled master
    rresp_cfg = 2'b10;
    exp_ar.push_back('{0, 32'h24});
    exp_r.push_back('{0, 32'h0024_FFDB, 2'b10});
    rv0 = rv_wait0; rt0 = rtrack_err;
    rd_txn(0, 32'h24, 5);
    chk("t5_rvalid_wait_cycles", 64'(rv_wait0 - rv0), 5);
    chk("t5_rready_tracking", 64'(rtrack_err - rt0), 0);
    rresp_cfg = 2'b00;

    // move wr pointer to 1, then reset while master 1 sits in W_RESP
    bresp_cfg = 2'b00;
    exp_aw.push_back('{0, 32'h50});
    exp_w.push_back('{32'h5050_5050, 4'hF});
    exp_b.push_back('{0, 32'h0, 2'b00});
    wr_txn(0, 32'h50, 32'h5050_5050, 4'hF);
    exp_aw.push_back('{1, 32'h60});
    exp_w.push_back('{32'h6060_6060, 4'hF});
    s_awaddr[63:32] = 32'h60; s_wdata[63:32] = 32'h6060_6060; s_wstrb[7:4] = 4'hF;
    s_awvalid[1] = 1; s_wvalid[1] = 1; s_bready[1] = 0;
    bv = 0;
    for (t = 0; t < 50 && !bv; t++) begin
      @(negedge aclk);
      a = s_awvalid[1] && s_awready[1];
      w = s_wvalid[1] && s_wready[1];
      bv = s_bvalid[1];
      @(posedge aclk); #1;
      if (a) s_awvalid[1] = 0;
      if (w) s_wvalid[1] = 0;
    end
    chk("t6_in_w_resp", 64'({s_bvalid[1], wr_busy}), 64'(2'b11));
    #3 aresetn = 0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    #1;
    chk("t6_rst_m_side", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 0);
    chk("t6_rst_s_side", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 0);
    chk("t6_rst_state", 64'({wr_grant, rd_grant, wr_busy, rd_busy}), 0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk); #1;

    // after reset both pointers restart at master 0
    exp_aw.push_back('{0, 32'h70}); exp_w.push_back('{32'h7070_7070, 4'hF});
    exp_b.push_back('{0, 32'h0, 2'b00});
    exp_aw.push_back('{1, 32'h74}); exp_w.push_back('{32'h7474_7474, 4'hF});
    exp_b.push_back('{1, 32'h0, 2'b00});
    exp_ar.push_back('{0, 32'h80}); exp_r.push_back('{0, 32'h0080_FF7F, 2'b00});
    exp_ar.push_back('{1, 32'h84}); exp_r.push_back('{1, 32'h0084_FF7B, 2'b00});
    fork
      wr_txn(0, 32'h70, 32'h7070_7070, 4'hF);
      wr_txn(1, 32'h74, 32'h7474_7474, 4'hF);
      rd_txn(0, 32'h80, 0);
      rd_txn(1, 32'h84, 0);
    join

    repeat (3) @(posedge aclk);
    chk("sb_aw_empty", 64'(exp_aw.size()), 0);
    chk("sb_w_empty", 64'(exp_w.size()), 0);
    chk("sb_b_empty", 64'(exp_b.size()), 0);
    chk("sb_ar_empty", 64'(exp_ar.size()), 0);
    chk("sb_r_empty", 64'(exp_r.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
